// File: rtl/sargantana_icache_line_fill_pkg.sv
// Shared types and default geometry for the instruction-cache line refill engine.
package sargantana_icache_line_fill_pkg;

    localparam int unsigned LFILL_TAG_WIDHT  = 20;
    localparam int unsigned LFILL_IDX_WIDTH  = 6;
    localparam int unsigned LFILL_WAY_WIDHT  = 512;
    localparam int unsigned LFILL_BEAT_WIDTH = 128;
    localparam int unsigned N_BEATS          = LFILL_WAY_WIDHT / LFILL_BEAT_WIDTH;

    typedef logic [LFILL_TAG_WIDHT+LFILL_IDX_WIDTH-1:0] line_addr_t;

    typedef enum logic [2:0] {
        LFILL_IDLE,
        LFILL_REQ,
        LFILL_RECV,
        LFILL_WRITE,
        LFILL_DRAIN
    } lfill_state_t;

endpackage

// File: rtl/sargantana_icache_line_fill_victim.sv
// Victim way picker: lowest invalid way, else a round-robin pointer that only
// advances when a write actually consumed it.
module sargantana_icache_lfill_victim #(
    parameter int unsigned N_WAY = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [N_WAY-1:0] valid_bits_i,
    input  logic             advance_i,
    output logic [N_WAY-1:0] victim_o
);

    localparam int unsigned PTR_W = $clog2(N_WAY);

    logic [PTR_W-1:0] rr_d, rr_q;
    logic             all_valid;

    assign all_valid = &valid_bits_i;

    always_comb begin
        victim_o = '0;
        // Scan downward so the lowest-index invalid way is the one that sticks.
        for (int i = int'(N_WAY) - 1; i >= 0; i--) begin
            if (!valid_bits_i[i]) begin
                victim_o    = '0;
                victim_o[i] = 1'b1;
            end
        end
        if (all_valid) begin
            victim_o = N_WAY'(1) << rr_q;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (advance_i && all_valid) begin
            rr_d = rr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/sargantana_icache_line_fill.sv
// Instruction-cache refill engine: one outstanding miss, beat collection into a
// line buffer, then a single-cycle tag/data/valid write to the chosen way.
module sargantana_icache_line_fill
    import sargantana_icache_line_fill_pkg::*;
#(
    parameter bit          LINES_256    = 1'b0,
    parameter int unsigned ICACHE_N_WAY = 4,
    parameter int unsigned TAG_WIDHT    = LFILL_TAG_WIDHT,
    parameter int unsigned IDX_WIDTH    = LFILL_IDX_WIDTH,
    parameter int unsigned WAY_WIDHT    = LFILL_WAY_WIDHT,
    parameter int unsigned BEAT_WIDTH   = LFILL_BEAT_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           miss_valid_i,
    output logic                           miss_ready_o,
    input  logic [TAG_WIDHT-1:0]           miss_tag_i,
    input  logic [IDX_WIDTH-1:0]           miss_idx_i,
    input  logic [ICACHE_N_WAY-1:0]        way_valid_bits_i,
    input  logic                           kill_i,
    output logic                           req_valid_o,
    input  logic                           req_ready_i,
    output logic [TAG_WIDHT+IDX_WIDTH-1:0] req_addr_o,
    input  logic                           resp_valid_i,
    input  logic [BEAT_WIDTH-1:0]          resp_data_i,
    input  logic                           resp_err_i,
    output logic [ICACHE_N_WAY-1:0]        we_o,
    output logic [IDX_WIDTH-1:0]           wr_idx_o,
    output logic [TAG_WIDHT-1:0]           wr_tag_o,
    output logic [WAY_WIDHT-1:0]           wr_data_o,
    output logic [ICACHE_N_WAY-1:0]        valid_set_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int unsigned LINE_W = LINES_256 ? 256 : WAY_WIDHT;
    localparam int unsigned NB     = LINE_W / BEAT_WIDTH;
    localparam int unsigned CNT_W  = (NB > 1) ? $clog2(NB) : 1;

    lfill_state_t            state_d, state_q;
    logic [TAG_WIDHT-1:0]    tag_d, tag_q;
    logic [IDX_WIDTH-1:0]    idx_d, idx_q;
    logic [ICACHE_N_WAY-1:0] vbits_d, vbits_q;
    logic [CNT_W-1:0]        beat_d, beat_q;
    logic                    err_d, err_q;
    logic                    err_pulse_d, err_pulse_q;
    logic [LINE_W-1:0]       line_d, line_q;
    logic                    last_beat;
    logic                    err_any;
    logic [ICACHE_N_WAY-1:0] victim;

    assign last_beat = (beat_q == CNT_W'(NB - 1));
    assign err_any   = err_q | resp_err_i;

    sargantana_icache_lfill_victim #(
        .N_WAY (ICACHE_N_WAY)
    ) u_victim (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .valid_bits_i (vbits_q),
        .advance_i    (state_q == LFILL_WRITE),
        .victim_o     (victim)
    );

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        idx_d       = idx_q;
        vbits_d     = vbits_q;
        beat_d      = beat_q;
        err_d       = err_q;
        err_pulse_d = 1'b0;
        line_d      = line_q;
        case (state_q)
            LFILL_IDLE: begin
                if (miss_valid_i) begin
                    tag_d   = miss_tag_i;
                    idx_d   = miss_idx_i;
                    vbits_d = way_valid_bits_i;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = LFILL_REQ;
                end
            end
            LFILL_REQ: begin
                if (req_ready_i) begin
                    state_d = kill_i ? LFILL_DRAIN : LFILL_RECV;
                end else if (kill_i) begin
                    state_d = LFILL_IDLE;
                end
            end
            LFILL_RECV: begin
                if (resp_valid_i) begin
                    line_d[int'(beat_q)*BEAT_WIDTH +: BEAT_WIDTH] = resp_data_i;
                    beat_d = beat_q + CNT_W'(1);
                    err_d  = err_any;
                    if (last_beat) begin
                        // A kill on the final beat simply drops the line.
                        if (kill_i) begin
                            state_d = LFILL_IDLE;
                        end else if (err_any) begin
                            state_d     = LFILL_IDLE;
                            err_pulse_d = 1'b1;
                        end else begin
                            state_d = LFILL_WRITE;
                        end
                    end else if (kill_i) begin
                        state_d = LFILL_DRAIN;
                    end
                end else if (kill_i) begin
                    state_d = LFILL_DRAIN;
                end
            end
            LFILL_DRAIN: begin
                if (resp_valid_i) begin
                    beat_d = beat_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d = LFILL_IDLE;
                    end
                end
            end
            LFILL_WRITE: begin
                state_d = LFILL_IDLE;
            end
            default: begin
                state_d = LFILL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= LFILL_IDLE;
            tag_q       <= '0;
            idx_q       <= '0;
            vbits_q     <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            err_pulse_q <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            vbits_q     <= vbits_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            err_pulse_q <= err_pulse_d;
            line_q      <= line_d;
        end
    end

    assign miss_ready_o = (state_q == LFILL_IDLE);
    assign req_valid_o  = (state_q == LFILL_REQ);
    assign req_addr_o   = {tag_q, idx_q};
    assign done_o       = (state_q == LFILL_WRITE);
    assign we_o         = done_o ? victim : '0;
    assign valid_set_o  = we_o;
    assign wr_idx_o     = idx_q;
    assign wr_tag_o     = tag_q;
    assign wr_data_o    = WAY_WIDHT'(line_q);
    assign err_o        = err_pulse_q;

endmodule

// File: doc/sargantana_icache_line_fill.md
# sargantana_icache_line_fill

Refill engine on the write side of the instruction-cache arrays. It accepts one miss at a time and issues a line request to the L2/memory interface. It then collects the response beats into a line buffer, picks a victim way, and writes tag, data and the way valid bit in a single cycle. It sits between the miss detection in the fetch pipeline and the tag/data/valid arrays that the hit-check logic later reads.

## Interface
- LINES_256, 1'b0, 1: line buffer width 256 b; 0: 512 b (WAY_WIDHT must match)
- ICACHE_N_WAY, 4, number of ways (power of two, ≥2)
- TAG_WIDHT, 20, tag width
- IDX_WIDTH, 6, set index width
- WAY_WIDHT, 512, line width in bits
- BEAT_WIDTH, 128, L2 response beat width; N_BEATS = WAY_WIDHT/BEAT_WIDTH
- clk_i  in  1  clock; one clock domain
- rstn_i  in  1  reset; synchronous, active-low
- miss_valid_i  in  1  miss request
- miss_ready_o  out  1  engine idle, miss accepted when valid&ready
- miss_tag_i  in  TAG_WIDHT  physical tag of missing line
- miss_idx_i  in  IDX_WIDTH  set index
- way_valid_bits_i  in  ICACHE_N_WAY  valid bits of the set, sampled at accept
- kill_i  in  1  abort current fill (flush/redirect)
- req_valid_o  out  1  line request to L2
- req_ready_i  in  1  L2 accepts request
- req_addr_o  out  TAG_WIDHT+IDX_WIDTH  line address {tag,idx}
- resp_valid_i  in  1  response beat valid (no backpressure)
- resp_data_i  in  BEAT_WIDTH  beat data, beat 0 = line bits [BEAT_WIDTH-1:0]
- resp_err_i  in  1  beat carries bus error
- we_o  out  ICACHE_N_WAY  one-hot array write enable
- wr_idx_o  out  IDX_WIDTH  set written
- wr_tag_o  out  TAG_WIDHT  tag written
- wr_data_o  out  WAY_WIDHT  assembled line
- valid_set_o  out  ICACHE_N_WAY  one-hot valid bit set, equal to we_o
- done_o  out  1  fill completed (one-cycle pulse, same cycle as write)
- err_o  out  1  fill dropped due to resp_err_i (one-cycle pulse)

## Operation
- FSM states: IDLE, REQ, RECV, WRITE, DRAIN.
- IDLE: miss_ready_o=1. On miss_valid_i, latch tag, idx and valid bits, clear beat_cnt and err flag, go to REQ.
- REQ: req_valid_o=1, req_addr_o held stable. On req_ready_i, go to RECV. If kill_i and not req_ready_i, go to IDLE. If kill_i and req_ready_i in the same cycle, go to DRAIN.
- RECV: each resp_valid_i writes resp_data_i into buffer slot beat_cnt, increments beat_cnt, and ORs resp_err_i into the err flag. On the last beat, go to WRITE if the err flag is clear, otherwise go to IDLE and pulse err_o. kill_i before the last beat moves the FSM to DRAIN, where beat counting continues. kill_i coincident with the last beat goes to IDLE and produces no write.
- DRAIN: count and discard beats. On the last beat, go to IDLE with no write and no err_o.
- WRITE: single cycle. Assert we_o/valid_set_o for the victim, wr_* and done_o, then go to IDLE. kill_i is ignored in WRITE.
- Victim selection: take the lowest-index zero in the latched valid bits. If all ways are valid, use the round-robin pointer rr_q. rr_q increments modulo ICACHE_N_WAY only on WRITE cycles that used it.
- resp_valid_i in IDLE or REQ is ignored.
- beat_cnt is $clog2(N_BEATS) bits and wraps to 0 after the last beat.

## Timing
- Reset values:
  - FSM = IDLE, rr_q = 0, beat_cnt = 0.
  - miss_ready_o = 1.
  - req_valid_o, we_o, valid_set_o, done_o and err_o = 0.
  - wr_data_o, wr_tag_o, wr_idx_o and req_addr_o = 0.
- Reset asserted mid-fill returns the FSM to IDLE on the next edge. No write occurs and late beats are ignored.
- Accept at cycle 0 → req_valid_o=1 from cycle 1.
- Write occurs on the cycle after the last beat; miss_ready_o=1 on the cycle after that.
- Minimum miss-to-write latency with zero-wait L2 is 2 + N_BEATS cycles.
- All outputs are registered or derive from FSM state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the FSM state enum `lfill_state_t`
  - N_BEATS
  - the line-address typedef
- One sub-module, sargantana_icache_lfill_victim: combinational first-invalid encoder plus rr_q register with an advance strobe.

## Test plan
- Single fill, set empty: miss tag 0xABCDE idx 5, beats 0x1..,0x2..,0x3..,0x4.. → we_o=0001, wr_data_o = {b3,b2,b1,b0}, done_o at last beat+1.
- Set with valid bits 1011 → victim way 2; all valid for three fills → ways 0,1,2 and rr_q=3.
- req_ready_i held low 10 cycles: req_valid_o and req_addr_o stable, miss_ready_o=0; a second miss_valid_i is not accepted.
- kill_i after beat 1: remaining beats drained, we_o stays 0, done_o stays 0, miss_ready_o=1 after last beat.
- resp_err_i on beat 2 → err_o pulse after last beat, no write, rr_q unchanged.
- rstn_i low during RECV → IDLE next cycle, all outputs at reset values, stray beats ignored.
